// File: rtl/sig_dma_pkg.sv
// Shared types and constants for the two-channel audio-memory DMA arbiter.
package sig_dma_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Sole pender wins; on a tie the channel not granted last time wins.
  function automatic logic rr_pick(input logic p0, input logic p1, input logic last);
    return (p0 & p1) ? ~last : p1;
  endfunction

endpackage

// File: rtl/sig_dma_req_latch.sv
// Holds one pulse-style request (addr/wdata/dir) until the arbiter issues it.
module sig_dma_req_latch
  import sig_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clr,
  output logic              pend,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] wdata_q,
  output logic              dir_q,
  output logic              overrun
);

  logic strobe;

  assign strobe  = read | write;
  // A pulse that arrives while a request is still held is dropped.
  assign overrun = strobe & pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= 1'b0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (strobe && !pend) begin
      pend    <= 1'b1;
      addr_q  <= addr;
      wdata_q <= write ? writedata : '0;
      dir_q   <= write;
    end
  end

endmodule

// File: rtl/sig_dma_arbiter.sv
// Round-robin share of one DMA memory port between the signal loader (ch0)
// and the feature writer (ch1), one transaction outstanding, with timeout.
//
//   state | meaning
//   IDLE  | waiting for a pending request; picks grant, loads mem strobe
//   ISSUE | mem strobe on the bus; clears granted pend, zeroes timer
//   WAIT  | waiting for mem_rdy or timer terminal count
module sig_dma_arbiter
  import sig_dma_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ch0_addr,
  input  logic              ch0_read,
  input  logic              ch0_write,
  input  logic [DATA_W-1:0] ch0_writedata,
  output logic [DATA_W-1:0] ch0_readdata,
  output logic              ch0_rdy,
  input  logic [ADDR_W-1:0] ch1_addr,
  input  logic              ch1_read,
  input  logic              ch1_write,
  input  logic [DATA_W-1:0] ch1_writedata,
  output logic [DATA_W-1:0] ch1_readdata,
  output logic              ch1_rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_rdy,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic              cur_write;
  logic [CNT_W-1:0]  cnt;

  logic              pend0, pend1;
  logic              dir0, dir1;
  logic              ovr0, ovr1;
  logic              clr0, clr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;

  logic              nxt_grant;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] resp_data;
  logic              tmo_hit;

  assign clr0 = (state == ISSUE) && (grant == CH0);
  assign clr1 = (state == ISSUE) && (grant == CH1);

  sig_dma_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req0 (
    .clk       (clk),
    .rst       (rst),
    .read      (ch0_read),
    .write     (ch0_write),
    .addr      (ch0_addr),
    .writedata (ch0_writedata),
    .clr       (clr0),
    .pend      (pend0),
    .addr_q    (addr0),
    .wdata_q   (wdata0),
    .dir_q     (dir0),
    .overrun   (ovr0)
  );

  sig_dma_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req1 (
    .clk       (clk),
    .rst       (rst),
    .read      (ch1_read),
    .write     (ch1_write),
    .addr      (ch1_addr),
    .writedata (ch1_writedata),
    .clr       (clr1),
    .pend      (pend1),
    .addr_q    (addr1),
    .wdata_q   (wdata1),
    .dir_q     (dir1),
    .overrun   (ovr1)
  );

  assign nxt_grant = rr_pick(pend0, pend1, last_grant);
  assign sel_write = (nxt_grant == CH1) ? dir1   : dir0;
  assign sel_addr  = (nxt_grant == CH1) ? addr1  : addr0;
  assign sel_wdata = (nxt_grant == CH1) ? wdata1 : wdata0;
  assign resp_data = cur_write ? '0 : mem_readdata;
  assign tmo_hit   = (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= CH0;
      last_grant    <= CH1;
      cur_write     <= 1'b0;
      cnt           <= '0;
      mem_addr      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      ch0_rdy       <= 1'b0;
      ch1_rdy       <= 1'b0;
      ch0_readdata  <= '0;
      ch1_readdata  <= '0;
      err_overrun   <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      // Strobes and completions are single-cycle pulses.
      mem_addr      <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      ch0_rdy       <= 1'b0;
      ch1_rdy       <= 1'b0;
      ch0_readdata  <= '0;
      ch1_readdata  <= '0;

      if (ovr0 || ovr1) err_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            grant         <= nxt_grant;
            last_grant    <= nxt_grant;
            cur_write     <= sel_write;
            mem_addr      <= sel_addr;
            mem_read      <= ~sel_write;
            mem_write     <= sel_write;
            mem_writedata <= sel_write ? sel_wdata : '0;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // A real completion beats a timeout landing in the same cycle.
          if (mem_rdy || tmo_hit) begin
            if (grant == CH0) begin
              ch0_rdy      <= 1'b1;
              ch0_readdata <= mem_rdy ? resp_data : '0;
            end else begin
              ch1_rdy      <= 1'b1;
              ch1_readdata <= mem_rdy ? resp_data : '0;
            end
            if (!mem_rdy) err_timeout <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
